// File: rtl/ifetch_unit.sv
// Instruction fetch front end: program counter, imem addressing and a small
// instruction queue toward decode. Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       QDEPTH   = 2,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-3:0] imem_add,
    input  logic [WIDTH-1:0] imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             fetch_fault
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        HALT = 2'd2
`endif
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [WIDTH-3:0] q_pc    [QDEPTH];
    logic [WIDTH-1:0] q_instr [QDEPTH];

    logic push, pop, misalign;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign misalign    = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    // Low target bits are simply truncated in this build.
    logic misalign_bits_unused;
    assign misalign_bits_unused = |redirect_pc[1:0];
    assign misalign    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_instr = out_valid ? q_instr[head_q] : '0;
    assign out_pc    = out_valid ? {q_pc[head_q], 2'b00} : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     push    = (count_q != FULL) || pop;
            default: state_d = state_q;
        endcase
        // A redirect wins over everything, including a push in the same cycle.
        if (redirect_valid) begin
            push = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            state_d = misalign ? HALT : RUN;
`else
            state_d = RUN;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            imem_add <= RESET_PC[WIDTH-1:2];
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                count_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                if (!misalign)
                    imem_add <= redirect_pc[WIDTH-1:2];
            end else begin
                if (push) begin
                    tail_q   <= tail_q + PTR_W'(1);
                    imem_add <= imem_add + (WIDTH-2)'(1);
                end
                if (pop)
                    head_q <= head_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_q <= 1'b0;
        else if (redirect_valid)
            fault_q <= misalign;
    end
`endif

    // NOTE: queue storage has no reset; entries are only read once count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_q]    <= imem_add;
            q_instr[tail_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit (QDEPTH=2, RESET_PC=0) with a
// combinational instruction memory model and hand-computed expectations.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] imem_add;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    int n_pass  = 0;
    int n_total = 0;

    ifetch_unit #(.WIDTH(32), .QDEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_add       (imem_add),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Words 0..3 hold 0x11111111..0x44444444; elsewhere 0xDEAD_<low 16 address bits>.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] k;
        if (a < 30'd4) begin
            k = 32'(a) + 32'd1;
            return 32'h1111_1111 * k;
        end
        return {16'hDEAD, a[15:0]};
    endfunction

    assign imem_data = mem_word(imem_add);

    typedef struct {
        bit          rst_before;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [29:0] e_add;
        bit          e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit rb, input bit rdy, input bit rv, input logic [31:0] rpc,
                                    input bit ev, input logic [31:0] epc, input logic [31:0] einstr,
                                    input logic [29:0] eadd, input bit ef);
        vec_t v;
        v.rst_before = rb; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = einstr; v.e_add = eadd; v.e_fault = ef;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #3;
        check({tag, " rst imem_add"},  64'(imem_add),    64'h0);
        check({tag, " rst out_valid"}, 64'(out_valid),   64'h0);
        check({tag, " rst out_instr"}, 64'(out_instr),   64'h0);
        check({tag, " rst out_pc"},    64'(out_pc),      64'h0);
        check({tag, " rst fault"},     64'(fetch_fault), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Stream with ready high: first capture two edges after release.
        add_vec(1, 1, 0, 0,             0, 0, 0,             30'd0, 0);
        add_vec(0, 1, 0, 0,             1, 32'h0, 32'h11111111, 30'd1, 0);
        add_vec(0, 1, 0, 0,             1, 32'h4, 32'h22222222, 30'd2, 0);
        add_vec(0, 1, 0, 0,             1, 32'h8, 32'h33333333, 30'd3, 0);
        add_vec(0, 1, 0, 0,             1, 32'hC, 32'h44444444, 30'd4, 0);
        // Backpressure after first capture, then release.
        add_vec(1, 0, 0, 0,             0, 0, 0,             30'd0, 0);
        add_vec(0, 0, 0, 0,             1, 32'h0, 32'h11111111, 30'd1, 0);
        for (int i = 0; i < 5; i++)
            add_vec(0, 0, 0, 0,         1, 32'h0, 32'h11111111, 30'd2, 0);
        add_vec(0, 1, 0, 0,             1, 32'h4, 32'h22222222, 30'd3, 0);
        add_vec(0, 1, 0, 0,             1, 32'h8, 32'h33333333, 30'd4, 0);
        add_vec(0, 1, 0, 0,             1, 32'hC, 32'h44444444, 30'd5, 0);
        // Redirect to 0x40 while full and popping.
        add_vec(0, 1, 1, 32'h40,        0, 0, 0,             30'h10, 0);
        add_vec(0, 1, 0, 0,             1, 32'h40, 32'hDEAD0010, 30'h11, 0);
        add_vec(0, 1, 0, 0,             1, 32'h44, 32'hDEAD0011, 30'h12, 0);
        // Word address wrap.
        add_vec(0, 1, 1, 32'hFFFFFFFC,  0, 0, 0,             30'h3FFFFFFF, 0);
        add_vec(0, 1, 0, 0,             1, 32'hFFFFFFFC, 32'hDEADFFFF, 30'h0, 0);
        add_vec(0, 1, 0, 0,             1, 32'h0, 32'h11111111, 30'h1, 0);
        // Misaligned redirect to 0x42.
`ifdef IFETCH_MISALIGN_TRAP_EN
        add_vec(0, 1, 1, 32'h42,        0, 0, 0,             30'h1, 1);
        add_vec(0, 1, 0, 0,             0, 0, 0,             30'h1, 1);
        add_vec(0, 1, 0, 0,             0, 0, 0,             30'h1, 1);
`else
        add_vec(0, 1, 1, 32'h42,        0, 0, 0,             30'h10, 0);
        add_vec(0, 1, 0, 0,             1, 32'h40, 32'hDEAD0010, 30'h11, 0);
        add_vec(0, 1, 0, 0,             1, 32'h44, 32'hDEAD0011, 30'h12, 0);
`endif
        add_vec(0, 1, 1, 32'h80,        0, 0, 0,             30'h20, 0);
        add_vec(0, 1, 0, 0,             1, 32'h80, 32'hDEAD0020, 30'h21, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before)
                do_reset($sformatf("v%0d", i));
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            check($sformatf("v%0d out_valid", i), 64'(out_valid),   64'(vecs[i].e_valid));
            check($sformatf("v%0d imem_add", i),  64'(imem_add),    64'(vecs[i].e_add));
            check($sformatf("v%0d fault", i),     64'(fetch_fault), 64'(vecs[i].e_fault));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d out_pc", i),    64'(out_pc),    64'(vecs[i].e_pc));
                check($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(vecs[i].e_instr));
            end
        end

        // Asynchronous reset mid-stream, then BOOT repeats.
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("mid pre-reset valid", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'h0);
        check("mid rst imem_add",  64'(imem_add),  64'h0);
        check("mid rst out_pc",    64'(out_pc),    64'h0);
        check("mid rst out_instr", 64'(out_instr), 64'h0);
        check("mid rst fault",     64'(fetch_fault), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("boot out_valid", 64'(out_valid), 64'h0);
        check("boot imem_add",  64'(imem_add),  64'h0);
        @(posedge clk);
        #1;
        check("boot cap valid", 64'(out_valid), 64'h1);
        check("boot cap pc",    64'(out_pc),    64'h0);
        check("boot cap instr", 64'(out_instr), 64'h11111111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
